mix_columns_engine: RTL and testbench
=====================================

Name: mix_columns_engine

Overview:
- Sequential, handshaked AES MixColumns / InvMixColumns engine for a 128-bit state, selectable per block.
- Processes COLS_PER_CYCLE columns per clock, trading area for latency.
- Sits between the ShiftRows/InvShiftRows and AddRoundKey stages of the iterative round datapath.
- Generalises the existing combinational inverse-only block with a forward/inverse mode, configurable throughput, valid/ready flow control and output holding under backpressure.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- Derived: STEPS = 4/COLS_PER_CYCLE, the number of transform cycles per block.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-high reset.
- mode  in  1  0 = MixColumns, 1 = InvMixColumns. Sampled on input handshake.
- in_valid  in  1  Input block valid.
- in_ready  out  1  Engine can accept a block.
- in_state  in  [0:127]  Input state. Byte k = bits 8k..8k+7. Column c = bytes 4c..4c+3; row 0 is the lowest byte.
- out_valid  out  1  Result valid.
- out_ready  in  1  Downstream accepts the result.
- out_state  out  [0:127]  Result, same byte ordering as in_state.
- busy  out  1  High in BUSY or DONE.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - out_valid = 0, busy = 0, out_state = 0, step counter = 0, latched mode = 0, internal state register = 0.
  - in_ready is 0 while rst is high and 1 on the first cycle after release.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready at a clock edge:
    - capture in_state into the working register;
    - latch mode;
    - clear the step counter;
    - go to BUSY.
  - BUSY: in_ready = 0. Each edge transforms columns [step*COLS_PER_CYCLE .. step*COLS_PER_CYCLE+COLS_PER_CYCLE-1] in place, then increments step. On the edge that processes the last group (step == STEPS-1), go to DONE.
  - DONE: out_valid = 1 and out_state = working register. Both hold stable while out_ready = 0. On out_valid && out_ready at an edge, go to IDLE and deassert out_valid.
- Latency: out_valid rises STEPS cycles after the accepting edge (4, 2 or 1).
- Throughput: one block per STEPS+2 cycles. There is no overlap: in_ready stays low from the accept edge until the output handshake has completed.
- Arithmetic is GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B).
  - xtime(b) = (b<<1) XOR (b[7] ? 0x1B : 0).
  - Forward column matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  - Inverse column matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - All products are built from xtime chains and XOR only; no multipliers, no lookup ROMs.
- Mode changes while BUSY or DONE have no effect. The latched mode governs the whole block.
- in_valid is ignored outside IDLE. in_state and mode need only be stable at the accepting edge.
- out_state is don't-care when out_valid = 0, but must not change during DONE.
- Reset asserted in BUSY or DONE aborts the block: no output is produced and the FSM returns to IDLE.
- out_ready high while out_valid is low has no effect.

Test Plan:
- mode=1, COLS_PER_CYCLE=1, in_state = bd6e7c3df2b5779e0b61216e8b10b689 -> out_state = 4773b91ff72f354361cb018ea1e6cf2c, out_valid rises exactly 4 cycles after the accept edge.
- mode=0, in_state = 4773b91ff72f354361cb018ea1e6cf2c -> bd6e7c3df2b5779e0b61216e8b10b689. Also check single columns: db135345 -> 8e4da1bc, f20a225c -> 9fdc589d.
- Back-to-back inverse vectors:
  - fde3bad205e5d0d73547964ef1fe37f1 -> 2d7e86a339d9393ee6570a1101904e16
  - d1876c0f79c4300ab45594add66ff41f -> 39daee38f4f1a82aaf432410c36d45b9
  - c62fe109f75eedc3cc79395d84f9cf5d -> 9a39bf1d05b20a3a476a0bf79fe51184
  - Required: in_ready low from accept until output handshake; in_valid held high during BUSY does not cause a second capture.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE and toggle mode and in_state meanwhile -> out_state and out_valid stay constant; one-cycle out_ready pulse returns the FSM to IDLE.
- Reset mid-operation: assert rst on the 2nd BUSY cycle -> out_valid = 0, busy = 0, out_state = 0 immediately; after release in_ready = 1 and a fresh block completes correctly.
- Repeat the first two scenarios with COLS_PER_CYCLE = 2 and 4 -> identical data, with latency 2 and 1 cycles respectively.

Source files
------------

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - sequential AES MixColumns/InvMixColumns engine with valid/ready handshakes
// Transforms COLS_PER_CYCLE columns of the working state per clock; the result is held until it is accepted.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);
  localparam int STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] STEP_LAST = 2'(STEPS - 1);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [1:0]   step;
  logic         mode_q;
  logic [0:127] work, work_nx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficient k is a 4-bit mask over {x8, x4, x2, x1}; every matrix entry fits in it.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] r [4];
    logic [3:0] m0, m1, m2, m3;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    m0 = inv ? 4'he : 4'h2;
    m1 = inv ? 4'hb : 4'h3;
    m2 = inv ? 4'hd : 4'h1;
    m3 = inv ? 4'h9 : 4'h1;
    // Each row of both matrices is the previous row rotated right by one.
    for (int i = 0; i < 4; i++) begin
      r[i] = gmul(a[i], m0) ^ gmul(a[(i+1)%4], m1) ^ gmul(a[(i+2)%4], m2) ^ gmul(a[(i+3)%4], m3);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 2'd0;
      mode_q <= 1'b0;
      work   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        work   <= in_state;
        mode_q <= mode;
        step   <= 2'd0;
      end else if (state == BUSY) begin
        work <= work_nx;
        step <= step + 2'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    work_nx   = work;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
          if ((c / COLS_PER_CYCLE) == int'(step)) begin
            work_nx[32*c +: 32] = mix_col(work[32*c +: 32], mode_q);
          end
        end
        if (step == STEP_LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_state = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - scoreboard bench for mix_columns_engine at 1, 2 and 4 columns per cycle
module tb_mix_columns_engine;
  localparam logic [0:127] INV_IN  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [0:127] INV_OUT = 128'h4773b91ff72f354361cb018ea1e6cf2c;
  localparam logic [0:127] COL_IN  = 128'hdb135345f20a225c01010101d4d4d4d5;
  localparam logic [0:127] COL_OUT = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;

  typedef struct {
    int           inst;
    logic [0:127] data;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [0:127] in_state;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bz   [3];
  logic [0:127] os   [3];
  logic         ovp  [3];

  exp_t         q[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;
  logic [0:127] bi [3];
  logic [0:127] bo [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[g]), .in_ready(ir[g]),
      .in_state(in_state), .out_valid(ov[g]), .out_ready(ordy[g]),
      .out_state(os[g]), .busy(bz[g])
    );
  end

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Checks every cycle an output is presented, so a result that drifts under backpressure is caught.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && ov[i]) begin
        if (q.size() == 0 || q[0].inst != i) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: inst %0d got %h expected none", i, os[i]);
        end else begin
          if (!ovp[i]) chk_i($sformatf("latency_inst%0d", i), cyc - q[0].acc, q[0].lat);
          chk_v($sformatf("data_inst%0d", i), os[i], q[0].data);
          if (ordy[i]) void'(q.pop_front());
        end
      end
      ovp[i] = ov[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one step after the accepting edge, with junk driven on the shared inputs.
  task automatic send(input int i, input logic [0:127] d, input logic m,
                      input logic [0:127] e, input int lat, input bit hold);
    int n;
    in_state = d;
    mode     = m;
    iv[i]    = 1'b1;
    n = 0;
    while (!ir[i] && n < 100) begin
      tick();
      n++;
    end
    if (!ir[i]) begin
      fail($sformatf("accept_timeout_inst%0d", i));
      iv[i] = 1'b0;
      return;
    end
    q.push_back('{i, e, cyc + 1, lat});
    tick();
    if (!hold) iv[i] = 1'b0;
    in_state = ~d;
    mode     = ~m;
    chk_b($sformatf("in_ready_low_after_accept_inst%0d", i), ir[i], 1'b0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      fail(name);
      q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bi[0] = 128'hfde3bad205e5d0d73547964ef1fe37f1;
    bo[0] = 128'h2d7e86a339d9393ee6570a1101904e16;
    bi[1] = 128'hd1876c0f79c4300ab45594add66ff41f;
    bo[1] = 128'h39daee38f4f1a82aaf432410c36d45b9;
    bi[2] = 128'hc62fe109f75eedc3cc79395d84f9cf5d;
    bo[2] = 128'h9a39bf1d05b20a3a476a0bf79fe51184;
    rst = 1'b1;
    mode = 1'b0;
    in_state = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      ovp[i] = 1'b0;
    end
    repeat (3) tick();
    chk_b("reset_out_valid", ov[0], 1'b0);
    chk_b("reset_busy", bz[0], 1'b0);
    chk_b("reset_in_ready", ir[0], 1'b0);
    chk_v("reset_out_state", os[0], '0);
    rst = 1'b0;
    #1;
    chk_b("release_in_ready", ir[0], 1'b1);

    send(0, INV_IN, 1'b1, INV_OUT, 4, 1'b0);
    wait_done("inv_done");
    send(0, INV_OUT, 1'b0, INV_IN, 4, 1'b0);
    wait_done("fwd_done");
    send(0, COL_IN, 1'b0, COL_OUT, 4, 1'b0);
    wait_done("col_done");

    // Back-to-back with in_valid held high throughout; next block is staged while the engine is busy.
    for (int k = 0; k < 3; k++) begin
      send(0, bi[k], 1'b1, bo[k], 4, 1'b1);
      n = 0;
      while (!ir[0] && n < 50) begin
        n++;
        if (n == 2) begin
          in_state = (k < 2) ? bi[k+1] : ~bi[k];
          mode = 1'b1;
        end
        tick();
      end
      chk_i("b2b_in_ready_low_cycles", n, 5);
    end
    iv[0] = 1'b0;
    wait_done("b2b_done");

    // Backpressure: inputs churn during DONE, the held result must not move.
    ordy[0] = 1'b0;
    send(0, INV_OUT, 1'b0, INV_IN, 4, 1'b0);
    n = 0;
    while (!ov[0] && n < 50) begin
      tick();
      n++;
    end
    if (!ov[0]) fail("bp_wait_valid");
    for (int k = 0; k < 5; k++) begin
      in_state = {4{$urandom}};
      mode = ~mode;
      iv[0] = ~iv[0];
      tick();
      chk_b("bp_out_valid_held", ov[0], 1'b1);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk_b("bp_out_valid_after_pulse", ov[0], 1'b0);
    chk_b("bp_in_ready_after_pulse", ir[0], 1'b1);
    chk_b("bp_busy_after_pulse", bz[0], 1'b0);
    chk_i("bp_queue_drained", q.size(), 0);
    ordy[0] = 1'b1;

    // Reset on the second BUSY cycle aborts the block.
    send(0, INV_IN, 1'b1, INV_OUT, 4, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk_b("abort_out_valid", ov[0], 1'b0);
    chk_b("abort_busy", bz[0], 1'b0);
    chk_v("abort_out_state", os[0], '0);
    chk_b("abort_in_ready", ir[0], 1'b0);
    q.delete();
    tick();
    rst = 1'b0;
    #1;
    chk_b("abort_release_in_ready", ir[0], 1'b1);
    send(0, INV_IN, 1'b1, INV_OUT, 4, 1'b0);
    wait_done("after_abort_done");

    send(1, INV_IN, 1'b1, INV_OUT, 2, 1'b0);
    wait_done("inv_done_c2");
    send(1, INV_OUT, 1'b0, INV_IN, 2, 1'b0);
    wait_done("fwd_done_c2");
    send(2, INV_IN, 1'b1, INV_OUT, 1, 1'b0);
    wait_done("inv_done_c4");
    send(2, COL_IN, 1'b0, COL_OUT, 1, 1'b0);
    wait_done("col_done_c4");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
